// File: rtl/accel_sha256_round_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : accel_sha256_round_engine_if
// Brief    : Block-in / digest-out handshake bundle for the SHA-256 engine.
// Revision : 1.0  initial release
// ============================================================================
interface accel_sha256_round_engine_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         abort;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] digest;
    logic         busy;

    modport master (
        output blk_valid, blk_data, blk_first, abort, dig_ready,
        input  blk_ready, dig_valid, digest, busy
    );

    modport slave (
        input  blk_valid, blk_data, blk_first, abort, dig_ready,
        output blk_ready, dig_valid, digest, busy
    );
endinterface
`default_nettype wire

// File: rtl/accel_sha256_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : accel_sha256_round_engine
// Brief    : SHA-256 compression of one 512-bit block, UNROLL rounds per clock,
//            with feed-forward and IV-start or chained operation.
// Revision : 1.0  initial release
// ============================================================================
module accel_sha256_round_engine #(
    parameter int UNROLL = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    accel_sha256_round_engine_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0]   C_STEP = 6'(UNROLL);
    localparam logic [5:0]   C_LAST = 6'(64 - UNROLL);
    localparam logic [255:0] C_IV   = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0]  C_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] f_bsig0(input logic [31:0] x);
        return f_rotr(x, 2) ^ f_rotr(x, 13) ^ f_rotr(x, 22);
    endfunction

    function automatic logic [31:0] f_bsig1(input logic [31:0] x);
        return f_rotr(x, 6) ^ f_rotr(x, 11) ^ f_rotr(x, 25);
    endfunction

    function automatic logic [31:0] f_ssig0(input logic [31:0] x);
        return f_rotr(x, 7) ^ f_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_ssig1(input logic [31:0] x);
        return f_rotr(x, 17) ^ f_rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t       r_state;
    logic [5:0]   r_cnt;
    logic [255:0] r_wrk;
    logic [255:0] r_base;
    logic [511:0] r_win;
    logic [255:0] r_digest;
    logic         r_dig_valid;
    logic         r_busy;

    logic         w_accept;
    logic [255:0] w_base;
    logic [255:0] w_sum;
    logic [255:0] w_st  [0:UNROLL];
    logic [511:0] w_win [0:UNROLL];

    assign bus.blk_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.dig_ready);
    assign bus.dig_valid = r_dig_valid;
    assign bus.digest    = r_digest;
    assign bus.busy      = r_busy;

    assign w_accept = bus.blk_valid && bus.blk_ready;
    assign w_base   = bus.blk_first ? C_IV : r_digest;

    // Chain of UNROLL combinational rounds; word 0 of each window sits in the top bits.
    assign w_st[0]  = r_wrk;
    assign w_win[0] = r_win;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
        logic [31:0]  w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
        logic [31:0]  w_kw, w_t1, w_t2, w_new;
        logic [5:0]   w_t;
        logic [511:0] w_cur;

        assign w_cur = w_win[gi];
        assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = w_st[gi];
        assign w_t   = r_cnt + 6'(gi);
        assign w_kw  = C_K[w_t] + w_cur[511:480];
        assign w_t1  = w_h + f_bsig1(w_e) + ((w_e & w_f) ^ (~w_e & w_g)) + w_kw;
        assign w_t2  = f_bsig0(w_a) + ((w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c));
        assign w_new = f_ssig1(w_cur[63:32]) + w_cur[223:192]
                     + f_ssig0(w_cur[479:448]) + w_cur[511:480];

        assign w_st[gi+1]  = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
        assign w_win[gi+1] = {w_cur[479:0], w_new};
    end

    for (genvar gj = 0; gj < 8; gj++) begin : g_feed_fwd
        assign w_sum[255-32*gj -: 32] = r_base[255-32*gj -: 32] + r_wrk[255-32*gj -: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wrk       <= '0;
            r_base      <= '0;
            r_win       <= '0;
            r_digest    <= '0;
            r_dig_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            // Acceptance only happens in IDLE or DONE, where abort has no effect.
            r_base      <= w_base;
            r_wrk       <= w_base;
            r_win       <= bus.blk_data;
            r_cnt       <= '0;
            r_dig_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_ROUND;
        end else begin
            case (r_state)
                S_ROUND: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_wrk <= w_st[UNROLL];
                        r_win <= w_win[UNROLL];
                        r_cnt <= r_cnt + C_STEP;
                        if (r_cnt == C_LAST) begin
                            r_state <= S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_digest    <= w_sum;
                        r_dig_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.dig_ready) begin
                        r_dig_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accel_sha256_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_sha256_round_engine
// Brief    : Self-checking bench: known vectors plus random blocks against a
//            plain-loop SHA-256 compression model.
// Revision : 1.0  initial release
// ============================================================================
module tb_accel_sha256_round_engine;

    localparam int T_UNROLL = 4;
    localparam int LAT      = 64 / T_UNROLL + 1;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [255:0] model_dig;
    logic [255:0] exp_dig;
    logic [255:0] saved;

    accel_sha256_round_engine_if bus_if ();

    accel_sha256_round_engine #(.UNROLL(T_UNROLL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
    function automatic logic [255:0] ref_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int j = 0; j < 8; j++) v[j] = h_in[255-32*j -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) r[255-32*j -: 32] = h_in[255-32*j -: 32] + v[j];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_block(input logic [511:0] d, input logic f);
        int n;
        bus_if.blk_data  = d;
        bus_if.blk_first = f;
        bus_if.blk_valid = 1'b1;
        bus_if.dig_ready = 1'b1;
        bus_if.abort     = 1'b0;
        n = 0;
        #1;
        while (!bus_if.blk_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 256'(n >= 200), 256'h0);
        exp_dig = ref_compress(f ? IV : model_dig, d);
        @(posedge clk); #1;
        bus_if.blk_valid = 1'b0;
        bus_if.dig_ready = 1'b0;
        bus_if.blk_first = ~f;
        for (int j = 0; j < 16; j++) bus_if.blk_data[511-32*j -: 32] = $urandom;
        chk("accept_busy", bus_if.busy, 1'b1);
        chk("accept_dv", bus_if.dig_valid, 1'b0);
    endtask

    task automatic wait_digest(input string tag);
        int lat;
        lat = 0;
        while (!bus_if.dig_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'(LAT));
        chk({tag, "_digest"}, bus_if.digest, exp_dig);
        chk({tag, "_busy"}, bus_if.busy, 1'b0);
        model_dig = exp_dig;
    endtask

    task automatic go_idle();
        bus_if.dig_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.dig_ready = 1'b0;
        chk("idle_dv", bus_if.dig_valid, 1'b0);
        chk("idle_ready", bus_if.blk_ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_dig = '0;
        exp_dig   = '0;
        bus_if.blk_valid = 1'b0;
        bus_if.blk_data  = '0;
        bus_if.blk_first = 1'b0;
        bus_if.abort     = 1'b0;
        bus_if.dig_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus_if.blk_ready, 1'b1);
        chk("rst_dv", bus_if.dig_valid, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_digest", bus_if.digest, 256'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single block "abc", then hold the digest under backpressure.
        send_block(BLK_ABC, 1'b1);
        wait_digest("abc");
        chk("abc_const", bus_if.digest, DIG_ABC);
        saved = bus_if.digest;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus_if.blk_valid = 1'b1;
                bus_if.blk_data  = BLK_EMPTY;
                bus_if.blk_first = 1'b1;
            end
            if (c == 5) bus_if.abort = 1'b1;
            @(posedge clk); #1;
            bus_if.blk_valid = 1'b0;
            bus_if.abort     = 1'b0;
            chk("bp_digest", bus_if.digest, saved);
            chk("bp_dv", bus_if.dig_valid, 1'b1);
            chk("bp_ready", bus_if.blk_ready, 1'b0);
            chk("bp_busy", bus_if.busy, 1'b0);
        end
        go_idle();

        send_block(BLK_EMPTY, 1'b1);
        wait_digest("empty");
        chk("empty_const", bus_if.digest, DIG_EMPTY);
        go_idle();

        // Two-block message; block 2 is offered in the same cycle dig_ready consumes block 1.
        send_block(BLK_TWO1, 1'b1);
        wait_digest("two1");
        send_block(BLK_TWO2, 1'b0);
        wait_digest("two2");
        chk("two_const", bus_if.digest, DIG_TWO);

        // Abort at counter 32, then "abc" again.
        send_block(BLK_ABC, 1'b1);
        repeat (32 / T_UNROLL) begin
            @(posedge clk); #1;
        end
        bus_if.abort = 1'b1;
        @(posedge clk); #1;
        bus_if.abort = 1'b0;
        chk("abort_busy", bus_if.busy, 1'b0);
        chk("abort_ready", bus_if.blk_ready, 1'b1);
        chk("abort_dv", bus_if.dig_valid, 1'b0);
        chk("abort_digest", bus_if.digest, DIG_TWO);
        repeat (LAT + 2) begin
            @(posedge clk); #1;
        end
        chk("abort_stays_idle", bus_if.dig_valid, 1'b0);
        send_block(BLK_ABC, 1'b1);
        wait_digest("abort_abc");
        chk("abort_abc_const", bus_if.digest, DIG_ABC);

        // Random blocks, mixed IV/chained starts, mixed back-to-back and idle gaps.
        for (int i = 0; i < 12; i++) begin
            logic [511:0] d;
            logic         f;
            for (int j = 0; j < 16; j++) d[511-32*j -: 32] = $urandom;
            f = ($urandom_range(0, 2) == 0);
            send_block(d, f);
            wait_digest("rand");
            if ($urandom_range(0, 1) == 1) begin
                go_idle();
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end

        // Asynchronous reset mid-ROUND.
        send_block(BLK_EMPTY, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus_if.busy, 1'b0);
        chk("arst_dv", bus_if.dig_valid, 1'b0);
        chk("arst_ready", bus_if.blk_ready, 1'b1);
        chk("arst_digest", bus_if.digest, 256'h0);
        model_dig = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Chaining straight after reset starts from an all-zero digest register.
        begin
            logic [511:0] d;
            for (int j = 0; j < 16; j++) d[511-32*j -: 32] = $urandom;
            send_block(d, 1'b0);
            wait_digest("zero_chain");
        end
        send_block(BLK_ABC, 1'b1);
        wait_digest("post_rst_abc");
        chk("post_rst_abc_const", bus_if.digest, DIG_ABC);
        go_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
